full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_pkg.sv | 15 +
 rtl/full_adder_bit.sv | 20 ++
 rtl/full_adder.sv | 70 +++++++
 tb/tb_full_adder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder ripple-carry block.
// Default widths and the carry-event counter saturation value.
package full_adder_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    // Largest value representable in a w-bit counter (w in 1..32).
    function automatic logic [31:0] cnt_sat(input int w);
        logic [32:0] v;
        v = (33'd1 << w) - 33'd1;
        return v[31:0];
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder cell.
// Chained by the top level into a ripple-carry adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic w_p;

    // Propagate term is shared by the sum and the carry.
    always_comb begin
        w_p   = a ^ b;
        sum   = w_p ^ cin;
        carry = (a & b) | (cin & w_p);
    end

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with combinational and registered results.
// Also counts clock edges on which the carry-out was set.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum_q;
    logic             r_carry_q;
    logic [CNT_W-1:0] r_cnt;

    assign w_c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder_bit u_bit (
                .a     (a[gi]),
                .b     (b[gi]),
                .cin   (w_c[gi]),
                .sum   (w_sum[gi]),
                .carry (w_c[gi+1])
            );
        end
    endgenerate

    // Combinational outputs; overflow is carry-in vs carry-out of the MSB.
    always_comb begin
        sum   = w_sum;
        carry = w_c[WIDTH];
        ovf   = w_c[WIDTH] ^ w_c[WIDTH-1];
    end

    // Register the result and count carry events, saturating at the top.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum_q   <= '0;
            r_carry_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sum_q   <= w_sum;
            r_carry_q <= w_c[WIDTH];
            if (w_c[WIDTH] && (r_cnt != CNT_MAX))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign sum_q     = r_sum_q;
    assign carry_q   = r_carry_q;
    assign carry_cnt = r_cnt;

endmodule

// File: tb/tb_full_adder.sv
// Directed testbench for full_adder.
// Three instances: 1-bit, 8-bit, and 1-bit with a 2-bit counter.
module tb_full_adder;

    logic clk;

    // 1-bit instance, 16-bit counter
    logic        rst1;
    logic [0:0]  a1, b1;
    logic        c1;
    logic [0:0]  s1, sq1;
    logic        co1, ov1, cq1;
    logic [15:0] cnt1;

    // 8-bit instance
    logic        rst8;
    logic [7:0]  a8, b8;
    logic        c8;
    logic [7:0]  s8, sq8;
    logic        co8, ov8, cq8;
    logic [15:0] cnt8;

    // 1-bit instance, 2-bit counter
    logic        rst2;
    logic [0:0]  a2, b2;
    logic        c2;
    logic [0:0]  s2, sq2;
    logic        co2, ov2, cq2;
    logic [1:0]  cnt2;

    int n_chk;
    int n_fail;

    full_adder #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst1), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .carry(co1), .ovf(ov1),
        .sum_q(sq1), .carry_q(cq1), .carry_cnt(cnt1)
    );

    full_adder #(.WIDTH(8), .CNT_W(16)) u8 (
        .clk(clk), .rst_n(rst8), .a(a8), .b(b8), .cin(c8),
        .sum(s8), .carry(co8), .ovf(ov8),
        .sum_q(sq8), .carry_q(cq8), .carry_cnt(cnt8)
    );

    full_adder #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst2), .a(a2), .b(b2), .cin(c2),
        .sum(s2), .carry(co2), .ovf(ov2),
        .sum_q(sq2), .carry_q(cq2), .carry_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst1 = 1'b0; rst8 = 1'b0; rst2 = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        a2 = 1'b1; b2 = 1'b1; c2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({sq1, cq1, cnt1} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_u1: got sq=%0d cq=%0d cnt=%0d want 0/0/0",
                     sq1, cq1, cnt1);
        end
        n_chk++;
        if ({sq8, cq8, cnt8} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_u8: got sq=%h cq=%0d cnt=%0d want 00/0/0",
                     sq8, cq8, cnt8);
        end
        n_chk++;
        if ({sq2, cq2, cnt2} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_u2: got sq=%0d cq=%0d cnt=%0d want 0/0/0",
                     sq2, cq2, cnt2);
        end
    endtask

    // Truth table with u1 held in reset: comb path must ignore reset.
    task automatic test_truth_table();
        logic [7:0] es;
        logic [7:0] ec;
        logic [2:0] v;
        es = 8'b1001_0110;
        ec = 8'b1110_1000;
        rst1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a1, b1, c1} = v;
            #10;
            n_chk++;
            if (s1 !== es[i] || co1 !== ec[i]) begin
                n_fail++;
                $display("FAIL tt_%0d: got sum=%0d carry=%0d want %0d/%0d",
                         i, s1, co1, es[i], ec[i]);
            end
        end
        n_chk++;
        if ({sq1, cq1, cnt1} !== 18'd0) begin
            n_fail++;
            $display("FAIL tt_regs_held: got sq=%0d cq=%0d cnt=%0d want 0",
                     sq1, cq1, cnt1);
        end
    endtask

    task automatic test_width8();
        logic [7:0] va [5];
        logic [7:0] vb [5];
        logic       vc [5];
        logic [7:0] xs [5];
        logic       xc [5];
        logic       xo [5];
        va = '{8'hFF, 8'h7F, 8'hFF, 8'h80, 8'h55};
        vb = '{8'h01, 8'h01, 8'hFF, 8'h80, 8'hAA};
        vc = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
        xs = '{8'h00, 8'h80, 8'hFF, 8'h00, 8'h00};
        xc = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
        xo = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        for (int i = 0; i < 5; i++) begin
            a8 = va[i]; b8 = vb[i]; c8 = vc[i];
            #1;
            n_chk++;
            if (s8 !== xs[i] || co8 !== xc[i] || ov8 !== xo[i]) begin
                n_fail++;
                $display("FAIL w8_%0d: got s=%h c=%0d o=%0d want %h/%0d/%0d",
                         i, s8, co8, ov8, xs[i], xc[i], xo[i]);
            end
        end
    endtask

    task automatic test_first_edge();
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (sq1 !== 1'b0 || cq1 !== 1'b1 || cnt1 !== 16'd1) begin
            n_fail++;
            $display("FAIL first_edge: got sq=%0d cq=%0d cnt=%0d want 0/1/1",
                     sq1, cq1, cnt1);
        end
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        #1;
        n_chk++;
        if (sq1 !== 1'b0 || cq1 !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_hold: got sq=%0d cq=%0d want 0/1",
                     sq1, cq1);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (sq1 !== 1'b1 || cq1 !== 1'b0 || cnt1 !== 16'd1) begin
            n_fail++;
            $display("FAIL latency_upd: got sq=%0d cq=%0d cnt=%0d want 1/0/1",
                     sq1, cq1, cnt1);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [6];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        @(negedge clk);
        rst2 = 1'b0;
        a2 = 1'b1; b2 = 1'b1; c2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (cnt2 !== exp_cnt[i] || sq2 !== 1'b1 || cq2 !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_%0d: got cnt=%0d sq=%0d cq=%0d want %0d/1/1",
                         i, cnt2, sq2, cq2, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst2 = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if (sq2 !== 1'b0 || cq2 !== 1'b0 || cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_prio: got sq=%0d cq=%0d cnt=%0d want 0/0/0",
                     sq2, cq2, cnt2);
        end
        n_chk++;
        if (s2 !== 1'b1 || co2 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_comb_a: got sum=%0d carry=%0d want 1/1",
                     s2, co2);
        end
        a2 = 1'b1; b2 = 1'b0; c2 = 1'b0;
        #1;
        n_chk++;
        if (s2 !== 1'b1 || co2 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_comb_b: got sum=%0d carry=%0d want 1/0",
                     s2, co2);
        end
        @(negedge clk);
        a2 = 1'b0; b2 = 1'b1; c2 = 1'b1;
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (sq2 !== 1'b0 || cq2 !== 1'b1 || cnt2 !== 2'd1) begin
            n_fail++;
            $display("FAIL rst_release: got sq=%0d cq=%0d cnt=%0d want 0/1/1",
                     sq2, cq2, cnt2);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst1 = 1'b0; rst8 = 1'b0; rst2 = 1'b0;
        a1 = '0; b1 = '0; c1 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;
        a2 = '0; b2 = '0; c2 = 1'b0;
        test_reset();
        test_truth_table();
        test_width8();
        test_first_edge();
        test_saturate();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
